ghost_catch_monitor: RTL and testbench
======================================

// Module: ghost_catch_monitor
// PURPOSE
//  Downstream consumer of the four ghost movers' x/y outputs. Compares each ghost position
//  against the Pac-Man position and debounces overlaps on the movement tick. A debounced
//  overlap is a catch: the monitor freezes play, decrements lives, pulses respawn to the
//  movers and score logic, and enters game-over when lives reach zero.
// PARAMETERS
//  N_GHOST      4   ghosts monitored; all ports are sized for 4.
//  HIT_DIST     8   overlap when |dx|<HIT_DIST and |dy|<HIT_DIST, in pixels.
//  HIT_TICKS    2   consecutive ticks with overlap required for a catch (1..15).
//  FREEZE_TICKS 64  ticks spent in CAUGHT before respawn or game-over (1..255).
//  LIVES        3   lives loaded at reset and at restart (1..3).
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-low
//  tick       in   1   movement strobe, one clk wide (same rate as the ghost-move divider)
//  start      in   1   restart request, one clk wide; honoured only in OVER
//  pac_x      in   10  Pac-Man x, pixels
//  pac_y      in   9   Pac-Man y, pixels
//  ghost_x    in   40  {g3,g2,g1,g0} ghost x, 10 b each
//  ghost_y    in   36  {g3,g2,g1,g0} ghost y, 9 b each
//  freeze     out  1   high in CAUGHT and OVER; movers hold position
//  respawn    out  1   one-clk pulse; movers reload their start positions
//  catch_id   out  2   index of the catching ghost, held until the next catch
//  lives      out  2   remaining lives
//  game_over  out  1   high in OVER
// BEHAVIOUR
//  Reset (rst=0, async): state=PLAY, lives=LIVES, freeze=0, respawn=0, catch_id=0,
//   game_over=0, hit_cnt=0, frz_cnt=0, hit_q=0.
//  Compare stage: for each ghost i, dx=|pac_x-gx_i| (10 b) and dy=|pac_y-gy_i| (9 b).
//   Compute each difference as larger minus smaller; no signed wrap.
//   hit_q[i] <= (dx<HIT_DIST)&&(dy<HIT_DIST), registered every clk (1-clk latency).
//  Any-hit = |hit_q. The winner is the lowest index with hit_q set.
//  State PLAY:
//   - on tick: if any-hit, hit_cnt <= hit_cnt+1 (saturating at HIT_TICKS); else hit_cnt <= 0.
//   - when a tick brings hit_cnt to HIT_TICKS, the following happen on that same edge:
//     state <= CAUGHT, catch_id <= winner, lives <= lives-1, frz_cnt <= 0, hit_cnt <= 0.
//   - start is ignored.
//  State CAUGHT: freeze=1. On tick, frz_cnt <= frz_cnt+1. When a tick makes frz_cnt reach
//   FREEZE_TICKS:
//   - if lives==0: state <= OVER.
//   - otherwise: state <= RESPAWN.
//   Hits are ignored during CAUGHT.
//  State RESPAWN: lasts exactly 1 clk. respawn=1, freeze=0. Next state is PLAY with hit_cnt=0.
//  State OVER: freeze=1, game_over=1. Stays here until start=1. Then state <= RESPAWN,
//   lives <= LIVES, catch_id is kept. This produces one respawn pulse before PLAY.
//  Output timing: all outputs are registered or decoded from registered state; no output is
//   a combinational function of the inputs. tick and start arriving together in PLAY:
//   tick is processed and start is ignored.
//  Catch latency: overlap present at clk edge E → hit_q set at E+1 → counted by a tick at
//   E+1 or later.
//  Reset asserted mid-CAUGHT or mid-OVER: returns to the reset values immediately; no
//   respawn pulse is emitted.
//  lives never underflows: a decrement happens only in PLAY, and in PLAY lives>=1.
// STRUCTURE
//  Shared header pacman_defs.vh: coordinate widths (X_W=10, Y_W=9), N_GHOST, and the state
//   encoding PLAY=2'd0, CAUGHT=2'd1, RESPAWN=2'd2, OVER=2'd3.
//  Sub-module ghost_hit_cmp (instantiated ×4): takes the abs-diff inputs and outputs the
//   registered hit bit.
//  Top level holds the FSM, the priority encoder, and the hit/freeze/lives counters.
// TESTING
//  1 Params 8/2/4/3. Ghost1 at (320,240) and pac at (325,236); two ticks → CAUGHT,
//    catch_id=1, lives=2, freeze=1.
//  2 Overlap on one tick only, then pac moves to (400,240) before the next tick → hit_cnt
//    clears; no catch, lives=3.
//  3 dx=8 exactly (pac_x=328, gx=320) → no hit. dx=7 → hit. Repeat with pac left of ghost
//    (pac_x=313) to check abs-diff.
//  4 Ghosts 0, 2 and 3 all overlapping → catch_id=0. After 4 ticks in CAUGHT, one respawn
//    pulse, then PLAY.
//  5 Three catches → OVER, game_over=1, lives=0. start → respawn pulse, lives=3, PLAY.
//    start in PLAY is ignored.
//  6 rst low in CAUGHT (frz_cnt=2) → all outputs at reset values asynchronously, with no
//    respawn pulse. Also check that overlap with no tick never advances hit_cnt.

Source files
------------

// File: rtl/ghost_catch_monitor_pkg.sv
// Shared definitions for the ghost catch monitor: coordinate widths, ghost count,
// FSM state encoding and the winner priority encoder.
package ghost_catch_monitor_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int N_GHOST = 4;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_CAUGHT  = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    // Lowest index with its bit set wins; returns 0 when nothing is set.
    function automatic logic [1:0] lowest_set(input logic [N_GHOST-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_GHOST - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ghost_catch_monitor_hit_cmp.sv
// Per-ghost overlap detector: absolute x/y distance to Pac-Man, registered hit bit.
module ghost_catch_monitor_hit_cmp
    import ghost_catch_monitor_pkg::*;
#(
    parameter int HIT_DIST = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [X_W-1:0] pac_x,
    input  logic [Y_W-1:0] pac_y,
    input  logic [X_W-1:0] gx,
    input  logic [Y_W-1:0] gy,
    output logic           hit_q
);

    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic           hit_d;

    // Larger minus smaller keeps the distance unsigned without wrap.
    assign dx    = (pac_x >= gx) ? (pac_x - gx) : (gx - pac_x);
    assign dy    = (pac_y >= gy) ? (pac_y - gy) : (gy - pac_y);
    assign hit_d = (dx < X_W'(HIT_DIST)) && (dy < Y_W'(HIT_DIST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hit_q <= 1'b0;
        else      hit_q <= hit_d;
    end

endmodule

// File: rtl/ghost_catch_monitor.sv
// Catch monitor: debounces ghost/Pac-Man overlaps on the movement tick, then runs the
// freeze, respawn, lives and game-over sequence.
module ghost_catch_monitor
    import ghost_catch_monitor_pkg::*;
#(
    parameter int HIT_DIST     = 8,
    parameter int HIT_TICKS    = 2,
    parameter int FREEZE_TICKS = 64,
    parameter int LIVES        = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic [X_W-1:0]         pac_x,
    input  logic [Y_W-1:0]         pac_y,
    input  logic [N_GHOST*X_W-1:0] ghost_x,
    input  logic [N_GHOST*Y_W-1:0] ghost_y,
    output logic                   freeze,
    output logic                   respawn,
    output logic [1:0]             catch_id,
    output logic [1:0]             lives,
    output logic                   game_over,
    output state_e                 state_dbg
);

    logic [N_GHOST-1:0] hit_q;
    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [1:0]         catch_id_q, catch_id_d;
    logic [3:0]         hit_cnt_q, hit_cnt_d;
    logic [7:0]         frz_cnt_q, frz_cnt_d;
    logic [3:0]         hit_cnt_inc;
    logic [7:0]         frz_cnt_inc;
    logic               any_hit;

    for (genvar g = 0; g < N_GHOST; g++) begin : g_cmp
        ghost_catch_monitor_hit_cmp #(.HIT_DIST(HIT_DIST)) u_cmp (
            .clk   (clk),
            .rst   (rst),
            .pac_x (pac_x),
            .pac_y (pac_y),
            .gx    (ghost_x[g*X_W +: X_W]),
            .gy    (ghost_y[g*Y_W +: Y_W]),
            .hit_q (hit_q[g])
        );
    end

    assign any_hit     = |hit_q;
    assign hit_cnt_inc = hit_cnt_q + 4'd1;
    assign frz_cnt_inc = frz_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        catch_id_d = catch_id_q;
        hit_cnt_d  = hit_cnt_q;
        frz_cnt_d  = frz_cnt_q;
        case (state_q)
            ST_PLAY: begin
                if (tick) begin
                    if (!any_hit) begin
                        hit_cnt_d = 4'd0;
                    end else if (hit_cnt_inc == 4'(HIT_TICKS)) begin
                        // lives is at least 1 whenever PLAY is active, so no underflow.
                        state_d    = ST_CAUGHT;
                        catch_id_d = lowest_set(hit_q);
                        lives_d    = lives_q - 2'd1;
                        frz_cnt_d  = 8'd0;
                        hit_cnt_d  = 4'd0;
                    end else begin
                        hit_cnt_d = hit_cnt_inc;
                    end
                end
            end
            ST_CAUGHT: begin
                if (tick) begin
                    frz_cnt_d = frz_cnt_inc;
                    if (frz_cnt_inc == 8'(FREEZE_TICKS)) begin
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
                    end
                end
            end
            ST_RESPAWN: begin
                state_d   = ST_PLAY;
                hit_cnt_d = 4'd0;
            end
            ST_OVER: begin
                if (start) begin
                    state_d = ST_RESPAWN;
                    lives_d = 2'(LIVES);
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_PLAY;
            lives_q    <= 2'(LIVES);
            catch_id_q <= 2'd0;
            hit_cnt_q  <= 4'd0;
            frz_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            catch_id_q <= catch_id_d;
            hit_cnt_q  <= hit_cnt_d;
            frz_cnt_q  <= frz_cnt_d;
        end
    end

    assign freeze    = (state_q == ST_CAUGHT) || (state_q == ST_OVER);
    assign respawn   = (state_q == ST_RESPAWN);
    assign game_over = (state_q == ST_OVER);
    assign catch_id  = catch_id_q;
    assign lives     = lives_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ghost_catch_monitor.sv
// Bench for ghost_catch_monitor: directed catch scenarios plus randomized positions and
// strobes, compared every cycle against a behavioural game model.
module tb_ghost_catch_monitor;
  import ghost_catch_monitor_pkg::*;

  localparam int HIT_DIST     = 8;
  localparam int HIT_TICKS    = 2;
  localparam int FREEZE_TICKS = 4;
  localparam int LIVES        = 3;

  // Phase numbering follows the documented state encoding.
  localparam int P_PLAY = 0, P_CAUGHT = 1, P_RESPAWN = 2, P_OVER = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pac_x = '0;
  logic [8:0]  pac_y = '0;
  logic [39:0] ghost_x = '0;
  logic [35:0] ghost_y = '0;
  logic        freeze, respawn, game_over;
  logic [1:0]  catch_id, lives;
  state_e      state_dbg;

  int checks = 0;
  int errors = 0;

  // Game-level positions and model state.
  int px, py;
  int gxs[4];
  int gys[4];
  int m_phase, m_lives, m_streak, m_frozen, m_catch;
  bit m_hit[4];

  ghost_catch_monitor #(
    .HIT_DIST(HIT_DIST), .HIT_TICKS(HIT_TICKS),
    .FREEZE_TICKS(FREEZE_TICKS), .LIVES(LIVES)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .freeze(freeze), .respawn(respawn), .catch_id(catch_id), .lives(lives),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] dut_outs();
    return {freeze, respawn, game_over, catch_id, lives, 2'(state_dbg)};
  endfunction

  function automatic logic [8:0] model_outs();
    logic f, r, o;
    f = (m_phase == P_CAUGHT) || (m_phase == P_OVER);
    r = (m_phase == P_RESPAWN);
    o = (m_phase == P_OVER);
    return {f, r, o, 2'(m_catch), 2'(m_lives), 2'(m_phase)};
  endfunction

  // ---------------- reference model ----------------
  function automatic bit overlap(input int ax, input int ay, input int bx, input int by);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < HIT_DIST) && (dy < HIT_DIST);
  endfunction

  task automatic model_reset();
    m_phase = P_PLAY; m_lives = LIVES; m_streak = 0; m_frozen = 0; m_catch = 0;
    for (int i = 0; i < 4; i++) m_hit[i] = 0;
  endtask

  task automatic model_edge(input bit t, input bit s);
    int winner;
    winner = -1;
    for (int i = 3; i >= 0; i--) if (m_hit[i]) winner = i;
    case (m_phase)
      P_PLAY: if (t) begin
        if (winner < 0) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak >= HIT_TICKS) begin
            m_phase = P_CAUGHT; m_catch = winner; m_lives--; m_frozen = 0; m_streak = 0;
          end
        end
      end
      P_CAUGHT: if (t) begin
        m_frozen++;
        if (m_frozen == FREEZE_TICKS) m_phase = (m_lives == 0) ? P_OVER : P_RESPAWN;
      end
      P_RESPAWN: begin m_phase = P_PLAY; m_streak = 0; end
      default: if (s) begin m_phase = P_RESPAWN; m_lives = LIVES; end
    endcase
    for (int i = 0; i < 4; i++) m_hit[i] = overlap(px, py, gxs[i], gys[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic apply_pos();
    pac_x = 10'(px); pac_y = 9'(py);
    for (int i = 0; i < 4; i++) begin
      ghost_x[i*10 +: 10] = 10'(gxs[i]);
      ghost_y[i*9 +: 9]   = 9'(gys[i]);
    end
  endtask

  task automatic set_far();
    px = 600; py = 400;
    for (int i = 0; i < 4; i++) begin gxs[i] = 20 + i * 50; gys[i] = 20; end
  endtask

  // One clock: drive strobes, advance model on the edge, compare on the falling edge.
  task automatic cycle(input bit t, input bit s);
    tick = t; start = s; apply_pos();
    @(posedge clk);
    model_edge(t, s);
    @(negedge clk);
    tick = 1'b0; start = 1'b0;
    check("outs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_far(); apply_pos();
    #2;
    model_reset();
    check("reset_outs", 32'(dut_outs()), 32'(9'b0_0_0_00_11_00));
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Ghost 2 overlaps, two ticks catch, then freeze runs out with Pac-Man away.
  task automatic catch_and_recover();
    gxs[2] = 100; gys[2] = 100; px = 103; py = 97;
    cycle(0, 0); cycle(1, 0); cycle(1, 0);
    set_far();
    repeat (FREEZE_TICKS) cycle(1, 0);
    cycle(0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_far(); apply_pos();
    #12;
    do_reset();

    // 1: ghost1 caught after two ticks
    gxs[1] = 320; gys[1] = 240; px = 325; py = 236;
    cycle(0, 0); cycle(1, 0);
    check("t1_no_catch_yet", 32'(state_dbg), P_PLAY);
    cycle(1, 0);
    check("t1_catch_id", 32'(catch_id), 1);
    check("t1_lives", 32'(lives), 2);
    check("t1_freeze", 32'(freeze), 1);

    // 2: single-tick overlap does not accumulate across a miss
    do_reset();
    gxs[1] = 320; gys[1] = 240; px = 325; py = 236;
    cycle(0, 0); cycle(1, 0);
    px = 400; py = 240;
    cycle(0, 0); cycle(1, 0);
    px = 325; py = 236;
    cycle(0, 0); cycle(1, 0);
    check("t2_state", 32'(state_dbg), P_PLAY);
    check("t2_lives", 32'(lives), 3);

    // 3: distance boundary on both sides of the ghost
    for (int k = 0; k < 4; k++) begin
      int xs[4];
      xs[0] = 328; xs[1] = 327; xs[2] = 312; xs[3] = 313;
      do_reset();
      gxs[0] = 320; gys[0] = 240; px = xs[k]; py = 240;
      cycle(0, 0); cycle(1, 0); cycle(1, 0);
      check("t3_boundary", 32'(state_dbg), (k % 2 == 1) ? P_CAUGHT : P_PLAY);
    end

    // 4: multiple overlaps, lowest index wins; freeze then one respawn pulse
    do_reset();
    gxs[0] = 320; gys[0] = 240; gxs[2] = 322; gys[2] = 238; gxs[3] = 318; gys[3] = 243;
    px = 320; py = 240;
    cycle(0, 0); cycle(1, 0); cycle(1, 0);
    check("t4_catch_id", 32'(catch_id), 0);
    set_far();
    repeat (FREEZE_TICKS - 1) cycle(1, 0);
    check("t4_still_frozen", 32'(freeze), 1);
    cycle(1, 0);
    check("t4_respawn", 32'(respawn), 1);
    cycle(0, 0);
    check("t4_play", 32'(state_dbg), P_PLAY);
    check("t4_respawn_off", 32'(respawn), 0);

    // 5: three catches end the game; start restarts, start in PLAY ignored
    do_reset();
    repeat (3) catch_and_recover();
    check("t5_game_over", 32'(game_over), 1);
    check("t5_lives", 32'(lives), 0);
    cycle(0, 1);
    check("t5_restart_respawn", 32'(respawn), 1);
    check("t5_restart_lives", 32'(lives), 3);
    cycle(0, 0);
    check("t5_play", 32'(state_dbg), P_PLAY);
    cycle(0, 1);
    check("t5_start_in_play", 32'(state_dbg), P_PLAY);

    // 6: async reset mid-freeze, and overlap without ticks never counts
    do_reset();
    gxs[1] = 320; gys[1] = 240; px = 325; py = 236;
    cycle(0, 0); cycle(1, 0); cycle(1, 0);
    cycle(1, 0); cycle(1, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6_async_reset", 32'(dut_outs()), 32'(9'b0_0_0_00_11_00));
    repeat (2) begin
      @(negedge clk);
      check("t6_no_respawn", 32'(respawn), 0);
    end
    rst = 1'b1;
    repeat (10) cycle(0, 0);
    cycle(1, 0);
    check("t6_one_tick_only", 32'(state_dbg), P_PLAY);
    cycle(1, 0);
    check("t6_second_tick", 32'(state_dbg), P_CAUGHT);

    // Randomized play around a small arena so overlaps are frequent.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        px = 300 + $urandom_range(0, 20); py = 200 + $urandom_range(0, 20);
        for (int i = 0; i < 4; i++) begin
          gxs[i] = 290 + $urandom_range(0, 40); gys[i] = 190 + $urandom_range(0, 40);
        end
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
